tpx3_tx_emu: RTL and testbench

TPX3_TX_EMU -- requirements
Module: tpx3_tx_emu

---
 rtl/tpx3_tx_emu.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_tpx3_tx_emu.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpx3_tx_emu.sv
// tpx3_tx_emu: Timepix3 serial link transmitter emulator.
// Each 48-bit packet is sent as six 8b10b data symbols, most significant byte first.
// Between packets the link sends K28.5 commas. Each CLK edge puts one bit on TX_OUT.
// Optional feature: define TX_ERR_INJECT_EN to add the ERR_INJECT input. A pulse on it
// flips bit a of the next data symbol, so the receiver sees a corrupted code.
module tpx3_tx_emu #(
  parameter int IDLE_MIN = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [47:0] DATA_IN,
  input  logic        DATA_VALID,
`ifdef TX_ERR_INJECT_EN
  input  logic        ERR_INJECT,
`endif
  output logic        DATA_READY,
  output logic        TX_OUT,
  output logic        SYMBOL_STROBE,
  output logic        BUSY
);

  localparam logic [7:0] LP_IDLE_MIN  = 8'(IDLE_MIN);
  localparam logic [9:0] LP_K285_NEG  = 10'b0011111010;
  localparam logic [9:0] LP_K285_POS  = 10'b1100000101;
  localparam logic [3:0] LP_LAST_BIT  = 4'd9;
  localparam logic [2:0] LP_LAST_BYTE = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [2:0]  r_byteIdx;
  logic [2:0]  w_byteIdxNext;
  logic [3:0]  r_bitCnt;
  logic [7:0]  r_commaCnt;
  logic [47:0] r_hold;
  logic        r_full;
  logic        r_ready;
  logic [47:0] r_txData;
  logic [9:0]  r_code;
  logic        r_rd;
  logic        r_txOut;
  logic        r_strobe;
  logic        r_busy;

  logic        w_boundary;
  logic        w_symStart;
  logic        w_accept;
  logic        w_launch;
  logic        w_fullNext;
  logic        w_isData;
  logic [7:0]  w_byte;
  logic [10:0] w_enc;
  logic [9:0]  w_symCode;
  logic        w_rdNext;
  logic        w_corrupt;

  // 5b/6b table, abcdei with a as the MSB. This column is for running disparity negative.
  function automatic logic [5:0] enc5b6bNeg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b table, fghj with f as the MSB. This column is for disparity negative.
  // The alt input selects the A7 code for D.x.7. A7 avoids a run of five equal bits.
  function automatic logic [3:0] enc3b4bNeg(input logic [2:0] y, input logic alt);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = alt ? 4'b0111 : 4'b1110;
    endcase
    return c;
  endfunction

  // Full 8b10b encode. The result is {running disparity after the symbol, abcdeifghj}.
  // When disparity is positive, unbalanced sub-blocks are complemented. D.07 and D.x.3
  // are also complemented: they are balanced but still depend on the running disparity.
  function automatic logic [10:0] encode8b10b(input logic [7:0] d, input logic rdIn);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       rdOut;
    logic       useAlt;
    x  = d[4:0];
    y  = d[7:5];
    c6 = enc5b6bNeg(x);
    if (rdIn && (($countones(c6) != 3) || (c6 == 6'b111000))) begin
      c6 = ~c6;
    end
    rd6    = ($countones(c6) != 3) ? ~rdIn : rdIn;
    useAlt = (y == 3'd7) &&
             ((!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
    c4 = enc3b4bNeg(y, useAlt);
    if (rd6 && (($countones(c4) != 2) || (c4 == 4'b1100))) begin
      c4 = ~c4;
    end
    rdOut = ($countones(c4) != 2) ? ~rd6 : rd6;
    return {rdOut, c6, c4};
  endfunction

  assign w_boundary = (r_bitCnt == LP_LAST_BIT);
  assign w_symStart = (r_bitCnt == 4'd0);
  assign w_accept   = DATA_VALID & r_ready;
  assign w_launch   = (r_state == ST_IDLE) & w_boundary & r_full &
                      (r_commaCnt >= LP_IDLE_MIN);
  assign w_fullNext = (r_full & ~w_launch) | w_accept;
  assign w_isData   = (r_state == ST_SEND);

  // Register FSM state and the byte index of the packet being sent.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_byteIdx <= 3'd0;
    end else begin
      r_state   <= w_stateNext;
      r_byteIdx <= w_byteIdxNext;
    end
  end

  // Next-state logic. The FSM moves only on the edge where the bit counter wraps 9->0.
  always_comb begin
    w_stateNext   = r_state;
    w_byteIdxNext = r_byteIdx;
    if (w_boundary) begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            w_stateNext   = ST_SEND;
            w_byteIdxNext = 3'd0;
          end
        end
        ST_SEND: begin
          if (r_byteIdx == LP_LAST_BYTE) begin
            w_stateNext   = ST_IDLE;
            w_byteIdxNext = 3'd0;
          end else begin
            w_byteIdxNext = r_byteIdx + 3'd1;
          end
        end
        default: begin
          w_stateNext   = ST_IDLE;
          w_byteIdxNext = 3'd0;
        end
      endcase
    end
  end

  // Count the bit position inside the current symbol. It runs 0..9 with no gaps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bitCnt <= 4'd0;
    end else if (w_boundary) begin
      r_bitCnt <= 4'd0;
    end else begin
      r_bitCnt <= r_bitCnt + 4'd1;
    end
  end

  // Holding register. The packet is copied out when it launches, which frees the slot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold   <= 48'd0;
      r_full   <= 1'b0;
      r_ready  <= 1'b0;
      r_txData <= 48'd0;
    end else begin
      if (w_accept) begin
        r_hold <= DATA_IN;
      end
      if (w_launch) begin
        r_txData <= r_hold;
      end
      r_full  <= w_fullNext;
      r_ready <= ~w_fullNext;
    end
  end

  // Count commas sent since the last packet. The count saturates so a long idle cannot wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_commaCnt <= 8'd0;
    end else if (w_launch) begin
      r_commaCnt <= 8'd0;
    end else if (w_symStart && !w_isData && (r_commaCnt != 8'hFF)) begin
      r_commaCnt <= r_commaCnt + 8'd1;
    end
  end

  // Select the current packet byte. Byte 0 is the top of the packet.
  always_comb begin
    w_byte = 8'd0;
    case (r_byteIdx)
      3'd0:    w_byte = r_txData[47:40];
      3'd1:    w_byte = r_txData[39:32];
      3'd2:    w_byte = r_txData[31:24];
      3'd3:    w_byte = r_txData[23:16];
      3'd4:    w_byte = r_txData[15:8];
      default: w_byte = r_txData[7:0];
    endcase
  end

  // Choose the symbol to send: the encoded data byte, or the comma that fits the current disparity.
  always_comb begin
    w_enc     = encode8b10b(w_byte, r_rd);
    w_symCode = r_rd ? LP_K285_POS : LP_K285_NEG;
    w_rdNext  = ~r_rd;
    if (w_isData) begin
      w_symCode = w_enc[9:0];
      w_rdNext  = w_enc[10];
    end
  end

`ifdef TX_ERR_INJECT_EN
  logic r_errArmed;

  // One-shot error arm. The flag clears when a corrupted symbol goes out. A new pulse re-arms it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_errArmed <= 1'b0;
    end else if (ERR_INJECT) begin
      r_errArmed <= 1'b1;
    end else if (w_corrupt) begin
      r_errArmed <= 1'b0;
    end
  end

  assign w_corrupt = r_errArmed & w_symStart & w_isData;
`else
  assign w_corrupt = 1'b0;
`endif

  // Serializer. The symbol and disparity are latched on the bit-a edge, then shifted out a..j.
  // Disparity always follows the clean code, even when bit a is flipped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_code   <= 10'd0;
      r_rd     <= 1'b0;
      r_txOut  <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_symStart) begin
      r_code   <= w_symCode;
      r_rd     <= w_rdNext;
      r_txOut  <= w_symCode[9] ^ w_corrupt;
      r_strobe <= 1'b1;
      r_busy   <= w_isData;
    end else begin
      r_txOut  <= r_code[LP_LAST_BIT - r_bitCnt];
      r_strobe <= 1'b0;
    end
  end

  assign DATA_READY    = r_ready;
  assign TX_OUT        = r_txOut;
  assign SYMBOL_STROBE = r_strobe;
  assign BUSY          = r_busy;

endmodule

// File: tb/tb_tpx3_tx_emu.sv
// tb_tpx3_tx_emu: directed bench for tpx3_tx_emu.
// A negedge monitor rebuilds 10-bit symbols from TX_OUT using SYMBOL_STROBE.
// It checks them with a table-driven 8b10b decoder and compares data bytes to a queue of expected bytes.
module tb_tpx3_tx_emu;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [47:0] DATA_IN = 48'd0;
  logic        DATA_VALID = 1'b0;
  logic        DATA_READY;
  logic        TX_OUT;
  logic        SYMBOL_STROBE;
  logic        BUSY;
`ifdef TX_ERR_INJECT_EN
  logic        ERR_INJECT = 1'b0;
`endif

  tpx3_tx_emu #(.IDLE_MIN(4)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .DATA_IN       (DATA_IN),
    .DATA_VALID    (DATA_VALID),
`ifdef TX_ERR_INJECT_EN
    .ERR_INJECT    (ERR_INJECT),
`endif
    .DATA_READY    (DATA_READY),
    .TX_OUT        (TX_OUT),
    .SYMBOL_STROBE (SYMBOL_STROBE),
    .BUSY          (BUSY)
  );

  always #5 CLK = ~CLK;

  localparam logic [9:0] K_NEG  = 10'b0011111010;
  localparam logic [9:0] K_POS  = 10'b1100000101;
  localparam logic [9:0] D00_N  = 10'b1001110100;

  int checks = 0;
  int errors = 0;

  logic [9:0] symQ[$];
  int         gapQ[$];
  logic [7:0] expQ[$];
  int         busyCycles = 0;
  int         dataSyms = 0;
  int         codeErrs = 0;
  int         alignErrs = 0;
  int         strobeErrs = 0;
  int         unexpData = 0;
  bit         cov[512];

  int         bitIdx = -1;
  int         busyBits = 0;
  int         commaRun = 0;
  logic [9:0] shiftW = 10'd0;
  logic       monRd = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference decoder: returns 1 on a code or disparity error. Fills in the byte and the new disparity.
  function automatic logic decodeSym(input logic [9:0] w, input logic rdIn,
                                     output logic [7:0] b, output logic rdOut);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [4:0] x;
    logic [2:0] y;
    logic       err;
    logic       r6;
    logic       alt;
    logic       need;
    int         o6;
    int         o4;
    s6 = w[9:4];
    s4 = w[3:0];
    x = 5'd0;
    y = 3'd0;
    err = 1'b0;
    case (s6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              err = 1'b1;
    endcase
    case (s4)
      4'b1011, 4'b0100:                   y = 3'd0;
      4'b1001:                            y = 3'd1;
      4'b0101:                            y = 3'd2;
      4'b1100, 4'b0011:                   y = 3'd3;
      4'b1101, 4'b0010:                   y = 3'd4;
      4'b1010:                            y = 3'd5;
      4'b0110:                            y = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: y = 3'd7;
      default:                            err = 1'b1;
    endcase
    o6 = $countones(s6);
    o4 = $countones(s4);
    if ((o6 > 3 && rdIn) || (o6 < 3 && !rdIn)) err = 1'b1;
    if ((s6 == 6'b111000 && rdIn) || (s6 == 6'b000111 && !rdIn)) err = 1'b1;
    r6 = (o6 != 3) ? ~rdIn : rdIn;
    if ((o4 > 2 && r6) || (o4 < 2 && !r6)) err = 1'b1;
    if ((s4 == 4'b1100 && r6) || (s4 == 4'b0011 && !r6)) err = 1'b1;
    if (y == 3'd7) begin
      alt  = (s4 == 4'b0111) || (s4 == 4'b1000);
      need = (!r6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( r6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
      if (alt != need) err = 1'b1;
    end
    rdOut = (o4 != 2) ? ~r6 : r6;
    b = {y, x};
    return err;
  endfunction

  task automatic processSymbol();
    logic [7:0] b;
    logic       rdn;
    symQ.push_back(shiftW);
    if (shiftW == K_NEG || shiftW == K_POS) begin
      if (shiftW != (monRd ? K_POS : K_NEG)) codeErrs++;
      if (busyBits != 0) alignErrs++;
      monRd = ~monRd;
      commaRun++;
    end else begin
      if (busyBits != 10) alignErrs++;
      if (commaRun > 0) gapQ.push_back(commaRun);
      commaRun = 0;
      if (decodeSym(shiftW, monRd, b, rdn)) codeErrs++;
      cov[{monRd, b}] = 1'b1;
      monRd = rdn;
      dataSyms++;
      if (expQ.size() == 0) unexpData++;
      else checkOutput("decByte", {56'd0, b}, {56'd0, expQ.pop_front()});
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the edge where the DUT updates them
  always @(negedge CLK) begin
    if (!RST_N) begin
      bitIdx   = -1;
      monRd    = 1'b0;
      commaRun = 0;
    end else begin
      if (BUSY) busyCycles++;
      if (SYMBOL_STROBE) begin
        if (bitIdx != -1 && bitIdx != 10) strobeErrs++;
        bitIdx   = 0;
        busyBits = 0;
      end else if (bitIdx == 10) begin
        strobeErrs++;
        bitIdx = -1;
      end
      if (bitIdx >= 0 && bitIdx < 10) begin
        shiftW = {shiftW[8:0], TX_OUT};
        if (BUSY) busyBits++;
        bitIdx++;
        if (bitIdx == 10) processSymbol();
      end
    end
  end

  task automatic clearScoreboard();
    symQ.delete();
    gapQ.delete();
    expQ.delete();
    busyCycles = 0;
    dataSyms   = 0;
    codeErrs   = 0;
    alignErrs  = 0;
    strobeErrs = 0;
    unexpData  = 0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    #1 RST_N = 1'b0;
    DATA_VALID = 1'b0;
    @(negedge CLK);
    #1 clearScoreboard();
    RST_N = 1'b1;
  endtask

  // Offer one packet. Valid is raised only when the DUT is ready, so the next rising edge accepts it.
  task automatic applyStimulus(input logic [47:0] pkt, input logic track);
    logic accepted;
    accepted = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (DATA_READY) begin
        DATA_IN    = pkt;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
        if (track) begin
          for (int k = 5; k >= 0; k--) expQ.push_back(pkt[8*k +: 8]);
        end
        accepted = 1'b1;
        break;
      end
    end
    checkOutput("accepted", {63'd0, accepted}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  logic [7:0] bb;
  int         covered;

  initial begin
    // Asynchronous reset values, and the first edge after release
    #2 RST_N = 1'b0;
    #10 checkOutput("rstOutputs", {60'd0, TX_OUT, SYMBOL_STROBE, BUSY, DATA_READY}, 64'd0);
    doReset();
    @(posedge CLK);
    #1;
    checkOutput("firstReady", {63'd0, DATA_READY}, 64'd1);
    checkOutput("firstStrobe", {63'd0, SYMBOL_STROBE}, 64'd1);
    checkOutput("firstBitA", {63'd0, TX_OUT}, 64'd0);
    repeat (50) @(negedge CLK);
    checkOutput("idleSym0", {54'd0, symQ[0]}, {54'd0, K_NEG});
    checkOutput("idleSym1", {54'd0, symQ[1]}, {54'd0, K_POS});
    checkOutput("idleSym2", {54'd0, symQ[2]}, {54'd0, K_NEG});
    checkOutput("idleSym3", {54'd0, symQ[3]}, {54'd0, K_POS});
    checkOutput("idleStrobe", strobeErrs, 0);
    checkOutput("idleBusy", busyCycles, 0);

    // All-zero packet starting from RD-
    doReset();
    applyStimulus(48'h0, 1'b1);
    repeat (150) @(negedge CLK);
    for (int i = 4; i < 10; i++) checkOutput($sformatf("d00sym%0d", i), {54'd0, symQ[i]}, {54'd0, D00_N});
    checkOutput("d00After", {54'd0, symQ[10]}, {54'd0, K_NEG});
    checkOutput("d00Gap", gapQ[0], 4);
    checkOutput("d00Busy", busyCycles, 60);
    checkOutput("d00Ready", {63'd0, DATA_READY}, 64'd1);
    checkOutput("d00Align", alignErrs, 0);
    checkOutput("d00Code", codeErrs, 0);

    // Two back-to-back packets: the second waits in the holding register
    doReset();
    applyStimulus(48'h123456789ABC, 1'b1);
    @(negedge CLK);
    checkOutput("pkt1Held", {63'd0, DATA_READY}, 64'd0);
    applyStimulus(48'hFFFFFFFFFFFF, 1'b1);
    @(negedge CLK);
    checkOutput("pkt2Held", {63'd0, DATA_READY}, 64'd0);
    repeat (250) @(negedge CLK);
    checkOutput("b2bSyms", dataSyms, 12);
    checkOutput("b2bGap", gapQ[1], 4);
    checkOutput("b2bBusy", busyCycles, 120);
    checkOutput("b2bDrain", expQ.size(), 0);
    checkOutput("b2bCode", codeErrs, 0);
    checkOutput("b2bUnexp", unexpData, 0);

    // Reset during byte 3 while a second packet is held
    doReset();
    applyStimulus(48'h010203040506, 1'b1);
    applyStimulus(48'hA5A5A5A5A5A5, 1'b1);
    for (int i = 0; i < 400 && dataSyms < 3; i++) @(negedge CLK);
    checkOutput("reachByte3", dataSyms, 3);
    repeat (5) @(negedge CLK);
    checkOutput("busyBefore", {63'd0, BUSY}, 64'd1);
    #2 RST_N = 1'b0;
    #1 checkOutput("midRst", {60'd0, TX_OUT, SYMBOL_STROBE, BUSY, DATA_READY}, 64'd0);
    @(negedge CLK);
    #1 clearScoreboard();
    RST_N = 1'b1;
    repeat (150) @(negedge CLK);
    checkOutput("rstNoData", dataSyms, 0);
    checkOutput("rstReady", {63'd0, DATA_READY}, 64'd1);
    checkOutput("rstCode", codeErrs, 0);
    checkOutput("rstSym0", {54'd0, symQ[0]}, {54'd0, K_NEG});

`ifdef TX_ERR_INJECT_EN
    // A one-shot error flips bit a of the first data symbol only
    doReset();
    @(negedge CLK);
    ERR_INJECT = 1'b1;
    @(negedge CLK);
    ERR_INJECT = 1'b0;
    applyStimulus(48'h0, 1'b0);
    repeat (150) @(negedge CLK);
    checkOutput("errSym4", {54'd0, symQ[4]}, 64'b0001110100);
    for (int i = 5; i < 10; i++) checkOutput($sformatf("errSym%0d", i), {54'd0, symQ[i]}, {54'd0, D00_N});
    checkOutput("errAfter", {54'd0, symQ[10]}, {54'd0, K_NEG});
`endif

    // Every byte value at both disparities: D3.0 between copies flips RD
    doReset();
    for (int i = 0; i < 512; i++) cov[i] = 1'b0;
    for (int b = 0; b < 256; b++) begin
      bb = 8'(b);
      applyStimulus({bb, 8'h03, bb, bb, 8'h03, bb}, 1'b1);
    end
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge CLK);
    repeat (20) @(negedge CLK);
    checkOutput("sweepDrain", expQ.size(), 0);
    covered = 0;
    for (int i = 0; i < 512; i++) if (cov[i]) covered++;
    checkOutput("sweepCover", covered, 512);
    checkOutput("sweepCode", codeErrs, 0);
    checkOutput("sweepAlign", alignErrs, 0);
    checkOutput("sweepStrobe", strobeErrs, 0);
    checkOutput("sweepUnexp", unexpData, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
